// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg : frame layout constants and controller state encoding       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_pkg;

    localparam int FRAME_W   = 16;
    localparam int WRITE_BIT = 15;
    localparam int ADDR_MSB  = 14;
    localparam int ADDR_LSB  = 8;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = ADDR_MSB - ADDR_LSB + 1;
    localparam int MAX_ADDR  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } ctrl_state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {wr, addr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_controller_if : command handshake and status between requester   |
// | and the SPI controller.  Revision: 1.0                               |
// +----------------------------------------------------------------------+
interface spi_controller_if;

    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [spi_pkg::ADDR_W-1:0] req_addr;
    logic [spi_pkg::DATA_W-1:0] req_data;
    logic                       busy;
    logic                       done;

    modport master (
        output req_valid, req_write, req_addr, req_data,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        output req_ready, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/spi_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_phase_timer : 8-bit loadable down-counter; expired marks the last |
// | cycle of a loaded interval.  Revision: 1.0                           |
// +----------------------------------------------------------------------+
module spi_phase_timer (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       load,
    input  wire logic [7:0] load_val,
    output logic            expired
);

    logic [7:0] r_count;

    // Loading N yields exactly N cycles before the reload edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign expired = (r_count == 8'd1);

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_controller : mode-0 SPI master sending one 16-bit write frame per |
// | accepted command.  Revision: 1.0                                     |
// +----------------------------------------------------------------------+
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    spi_controller_if.slave  bus,
    output logic             sclk,
    output logic             COPI,
    output logic             nCS
);

    ctrl_state_t        r_state;
    logic [FRAME_W-1:0] r_shreg;
    logic [3:0]         r_bit_cnt;
    logic               r_phase_hi;
    logic               r_sclk;
    logic               r_copi;
    logic               r_ncs;
    logic               r_busy;
    logic               r_done;

    logic               w_load;
    logic [7:0]         w_load_val;
    logic               w_expired;
    logic [FRAME_W-1:0] w_frame;

    assign w_frame = pack_frame(bus.req_write, bus.req_addr, bus.req_data);

    spi_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    // Reload value is the length of whichever interval starts on this edge.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = 8'(CLK_DIV);
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_load     = 1'b1;
                    w_load_val = 8'(CS_SETUP);
                end
            end
            ST_SETUP: w_load = w_expired;
            ST_SHIFT: begin
                if (w_expired) begin
                    w_load = 1'b1;
                    if (r_phase_hi && (r_bit_cnt == 4'd0)) begin
                        w_load_val = 8'(CS_HOLD);
                    end
                end
            end
            ST_HOLD: begin
                if (w_expired) begin
                    w_load     = 1'b1;
                    w_load_val = 8'(CS_GAP);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= 4'd0;
            r_phase_hi <= 1'b0;
            r_sclk     <= 1'b0;
            r_copi     <= 1'b0;
            r_ncs      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_shreg <= w_frame;
                        r_copi  <= w_frame[WRITE_BIT];
                        r_ncs   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_expired) begin
                        r_bit_cnt  <= 4'(FRAME_W - 1);
                        r_phase_hi <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_expired) begin
                        if (!r_phase_hi) begin
                            r_sclk     <= 1'b1;
                            r_phase_hi <= 1'b1;
                        end else begin
                            r_sclk     <= 1'b0;
                            r_phase_hi <= 1'b0;
                            if (r_bit_cnt == 4'd0) begin
                                r_copi  <= 1'b0;
                                r_state <= ST_HOLD;
                            end else begin
                                r_copi    <= r_shreg[r_bit_cnt - 4'd1];
                                r_bit_cnt <= r_bit_cnt - 4'd1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_expired) begin
                        r_ncs   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_expired) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign sclk          = r_sclk;
    assign COPI          = r_copi;
    assign nCS           = r_ncs;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_controller : directed + random frames against a frame-level   |
// | reference model.  Revision: 1.0                                      |
// +----------------------------------------------------------------------+
module tb_spi_controller;
    import spi_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;
    localparam int B_DIV    = 2;
    localparam int B_GAP    = 1;
    localparam int LOW_LEN  = CS_SETUP + 2 * FRAME_W * CLK_DIV + CS_HOLD;
    localparam int PERIOD   = LOW_LEN + CS_GAP + 1;
    localparam int B_LEN    = CS_SETUP + 2 * FRAME_W * B_DIV + CS_HOLD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_controller_if bus ();
    spi_controller_if bus_b ();
    logic sclk, copi, ncs, sclk_b, copi_b, ncs_b;

    spi_controller #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .sclk(sclk), .COPI(copi), .nCS(ncs)
    );
    spi_controller #(.CLK_DIV(B_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(B_GAP)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .sclk(sclk_b), .COPI(copi_b), .nCS(ncs_b)
    );

    int checks = 0;
    int failures = 0;

    // Frame-level observations of the default instance, gathered on the falling edge.
    int cyc = 0, rises = 0, low_cnt = 0, stable = 0, rise_cyc = 0, nrise_cyc = 0, high_cnt = 0;
    int min_setup = 1000, min_hold = 1000, done_cnt = 0, done_bad = 0;
    bit rise_seen = 0;
    logic p_sclk = 1'b0, p_copi = 1'b0, p_ncs = 1'b1, p_ready = 1'b1;
    logic [15:0] sh = '0;
    logic [15:0] q_frame[$];
    logic [15:0] exp_q[$];
    int q_len[$], q_rises[$], q_accept[$], q_gap[$], q_high[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (!(ncs === 1'b1 && p_ncs === 1'b0)) done_bad++;
        end
        if (ncs === 1'b0) begin
            if (p_ncs === 1'b1) begin
                rises = 0; sh = '0; low_cnt = 0; rise_seen = 0; stable = 0;
                q_high.push_back(high_cnt);
            end
            low_cnt++;
            stable = (copi === p_copi && p_ncs === 1'b0) ? stable + 1 : 1;
            if (sclk === 1'b1 && p_sclk === 1'b0) begin
                sh = {sh[14:0], copi};
                rises++;
                if (stable - 1 < min_setup) min_setup = stable - 1;
                rise_cyc = cyc;
                rise_seen = 1;
            end
            if (copi !== p_copi && p_ncs === 1'b0 && rise_seen && (cyc - rise_cyc) < min_hold)
                min_hold = cyc - rise_cyc;
        end else if (p_ncs === 1'b0) begin
            q_frame.push_back(sh);
            q_len.push_back(low_cnt);
            q_rises.push_back(rises);
            nrise_cyc = cyc;
            high_cnt = 1;
        end else begin
            high_cnt++;
        end
        if (bus.req_ready === 1'b1 && p_ready === 1'b0) q_gap.push_back(cyc - nrise_cyc);
        if (bus.req_ready === 1'b0 && p_ready === 1'b1) q_accept.push_back(cyc);
        p_sclk = sclk; p_copi = copi; p_ncs = ncs; p_ready = bus.req_ready;
    end

    // Reduced observer for the fast-clock instance.
    int cyc_b = 0, b_cnt = 0, b_r = 0, b_lr = -1, b_per = 0, b_len = 0, b_rises = 0;
    bit b_ok = 0;
    logic [15:0] b_sh = '0, b_frame = '0;
    logic p_sclk_b = 1'b0, p_ncs_b = 1'b1;

    always @(negedge clk) begin
        cyc_b++;
        if (ncs_b === 1'b0) begin
            if (p_ncs_b === 1'b1) begin b_cnt = 0; b_r = 0; b_sh = '0; b_lr = -1; end
            b_cnt++;
            if (sclk_b === 1'b1 && p_sclk_b === 1'b0) begin
                b_sh = {b_sh[14:0], copi_b};
                b_r++;
                if (b_lr >= 0) b_per = cyc_b - b_lr;
                b_lr = cyc_b;
            end
        end else if (p_ncs_b === 1'b0) begin
            b_len = b_cnt; b_frame = b_sh; b_rises = b_r; b_ok = 1;
        end
        p_sclk_b = sclk_b; p_ncs_b = ncs_b;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ge(input string tag, input int obs, input int lim);
        checks++;
        assert (obs >= lim) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected>=%0d", tag, obs, lim);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (bus.req_ready !== 1'b1 && k < 2000) begin tick(); k++; end
        check("ready_timeout", bus.req_ready, 1);
    endtask

    task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
        wait_ready();
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_data = d;
        exp_q.push_back({w, a, d});
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (q_frame.size() < n && k < 2000) begin tick(); k++; end
        check_ge("frame_timeout", q_frame.size(), n);
    endtask

    task automatic check_frame(input string tag);
        if (q_frame.size() != 0 && exp_q.size() != 0) begin
            check({tag, "_frame"}, q_frame.pop_front(), exp_q.pop_front());
            check({tag, "_ncs_low"}, q_len.pop_front(), LOW_LEN);
            check({tag, "_rises"}, q_rises.pop_front(), FRAME_W);
        end
    endtask

    task automatic flush();
        q_frame.delete(); exp_q.delete(); q_len.delete(); q_rises.delete();
        q_accept.delete(); q_gap.delete(); q_high.delete();
    endtask

    initial begin
        int k;
        int done_before;
        logic [15:0] r;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_data = '0;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0; bus_b.req_data = '0;

        repeat (3) tick();
        check("rst_sclk", sclk, 0);
        check("rst_copi", copi, 0);
        check("rst_ncs", ncs, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ready", bus.req_ready, 1);
        rst_n = 1'b1;
        tick();
        flush();
        done_cnt = 0;

        // Single write 0x00/0xA5
        send(1'b1, 7'h00, 8'hA5);
        check("accept_ready_low", bus.req_ready, 0);
        check("accept_busy", bus.busy, 1);
        wait_frames(1);
        check_frame("a5");
        check("a5_done_cnt", done_cnt, 1);
        check_ge("copi_setup", min_setup, CLK_DIV);
        check_ge("copi_hold", min_hold, CLK_DIV);
        k = 0;
        while (q_gap.size() == 0 && k < 100) begin tick(); k++; end
        check_ge("gap_seen", q_gap.size(), 1);
        if (q_gap.size() != 0) check("ready_return", q_gap[0], CS_GAP);
        check("idle_busy", bus.busy, 0);

        // Back-to-back with req_valid held
        wait_ready();
        q_accept.delete(); q_high.delete();
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'h01; bus.req_data = 8'h3C;
        exp_q.push_back(16'h813C);
        tick();
        bus.req_addr = 7'h02; bus.req_data = 8'hC3;
        exp_q.push_back(16'h82C3);
        wait_ready();
        tick();
        bus.req_valid = 1'b0;
        wait_frames(2);
        check_frame("b2b_1");
        check_frame("b2b_2");
        check("b2b_accepts", q_accept.size(), 2);
        if (q_accept.size() >= 2) check("b2b_period", q_accept[1] - q_accept[0], PERIOD);
        if (q_high.size() != 0) check("b2b_ncs_high", q_high[q_high.size() - 1], CS_GAP + 1);
        check("b2b_done_cnt", done_cnt, 3);

        // Command inputs toggling during the frame
        send(1'b0, 7'h55, 8'h96);
        k = 0;
        while (q_frame.size() == 0 && k < 2000) begin
            bus.req_write = 1'($urandom);
            bus.req_addr  = 7'($urandom);
            bus.req_data  = 8'($urandom);
            tick(); k++;
        end
        wait_frames(1);
        check_frame("toggle");

        // Random frames with random idle spacing
        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom);
            repeat ($urandom_range(0, 5)) tick();
            send(r[15], r[14:8], r[7:0]);
            wait_frames(1);
            check_frame($sformatf("rnd%0d", i));
        end
        check_ge("min_setup_all", min_setup, CLK_DIV);
        check_ge("min_hold_all", min_hold, CLK_DIV);

        // Reset during bit 7 high phase (ninth sclk rise)
        r = 16'($urandom);
        send(r[15], r[14:8], r[7:0]);
        k = 0;
        while (!(rises == 9 && sclk === 1'b1 && ncs === 1'b0) && k < 2000) begin tick(); k++; end
        check("bit7_reached", rises, 9);
        done_before = done_cnt;
        rst_n = 1'b0;
        tick();
        check("mid_rst_ncs", ncs, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_copi", copi, 0);
        check("mid_rst_ready", bus.req_ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        repeat (200) tick();
        check("mid_rst_no_done", done_cnt, done_before);
        flush();

        // Fast instance, CLK_DIV=2
        r = 16'($urandom);
        check("b_ready", bus_b.req_ready, 1);
        bus_b.req_valid = 1'b1; bus_b.req_write = r[15]; bus_b.req_addr = r[14:8]; bus_b.req_data = r[7:0];
        tick();
        bus_b.req_valid = 1'b0;
        k = 0;
        while (!b_ok && k < 500) begin tick(); k++; end
        check("b_done_seen", 32'(b_ok), 1);
        check("b_frame", b_frame, r);
        check("b_ncs_low", b_len, B_LEN);
        check("b_rises", b_rises, FRAME_W);
        check("b_sclk_period", b_per, 2 * B_DIV);

        check("done_alignment", done_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
